// File: rtl/shift_unit_iter_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared encodings for the iterative shift unit and anything else in the ALU
//   that wants to speak the same op/state language.
//   Contents:
//     shift_op_t      2-bit shift operation code
//     SHIFT_OP_*      SLL / SRL / SRA / ROL encodings
//     shift_state_t   FSM state type of shift_unit_iter
//     ST_*            IDLE / SHIFT / DONE encodings
// -----------------------------------------------------------------------------
package shift_pkg;

   typedef logic [1:0] shift_op_t;

   localparam shift_op_t SHIFT_OP_SLL = 2'b00;
   localparam shift_op_t SHIFT_OP_SRL = 2'b01;
   localparam shift_op_t SHIFT_OP_SRA = 2'b10;
   localparam shift_op_t SHIFT_OP_ROL = 2'b11;

   typedef logic [1:0] shift_state_t;

   localparam shift_state_t ST_IDLE  = 2'd0;
   localparam shift_state_t ST_SHIFT = 2'd1;
   localparam shift_state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_unit_iter_if.sv
// -----------------------------------------------------------------------------
// shift_unit_iter_if
//   Request/response bundle of the iterative shift unit.
//   Request side : in_valid, in_ready, data_in, shamt, op
//   Response side: out_valid, out_ready, data_out
//   Modports:
//     master - the operand source / result consumer
//     slave  - the shift unit itself
// -----------------------------------------------------------------------------
interface shift_unit_iter_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
);
   import shift_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   data_in;
   logic [SHAMT_W-1:0] shamt;
   shift_op_t          op;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   data_out;

   modport master (
      output in_valid, data_in, shamt, op, out_ready,
      input  in_ready, out_valid, data_out
   );

   modport slave (
      input  in_valid, data_in, shamt, op, out_ready,
      output in_ready, out_valid, data_out
   );

endinterface

// File: rtl/shift_unit_iter_step.sv
// -----------------------------------------------------------------------------
// shift_step_unit
//   Combinational single-step shifter: moves work_i by k_i (0..STEP) positions
//   in the mode given by op_i. Built as a ladder of log2(STEP)+1 fixed-shift
//   mux levels, level i shifting by 2**i when k_i[i] is set.
//   Ports:
//     work_i  in  WIDTH          word to shift
//     k_i     in  $clog2(STEP+1) shift amount, 0..STEP
//     op_i    in  2              SLL / SRL / SRA / ROL
//     work_o  out WIDTH          shifted word
// -----------------------------------------------------------------------------
module shift_step_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input  logic [WIDTH-1:0]           work_i,
   input  logic [$clog2(STEP+1)-1:0]  k_i,
   input  shift_op_t                  op_i,
   output logic [WIDTH-1:0]           work_o
);

   localparam int K_W = $clog2(STEP+1);

   // Fixed-amount shift. amt may reach or exceed WIDTH on the top level of a
   // wide ladder, so those cases are resolved explicitly.
   function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] w,
                                                 input int amt,
                                                 input shift_op_t op);
      logic signed [WIDTH-1:0] sw;
      int                      r;
      sw = w;
      r  = amt % WIDTH;
      case (op)
         SHIFT_OP_SLL: shift_by = (amt >= WIDTH) ? '0 : (w << amt);
         SHIFT_OP_SRL: shift_by = (amt >= WIDTH) ? '0 : (w >> amt);
         SHIFT_OP_SRA: shift_by = (amt >= WIDTH) ? {WIDTH{w[WIDTH-1]}}
                                                 : $unsigned(sw >>> amt);
         default:      shift_by = (r == 0) ? w : ((w << r) | (w >> (WIDTH - r)));
      endcase
   endfunction

   for (genvar i = 0; i < K_W; i++) begin : g_lvl
      logic [WIDTH-1:0] src;
      logic [WIDTH-1:0] res;
      if (i == 0) begin : g_first
         assign src = work_i;
      end else begin : g_next
         assign src = g_lvl[i-1].res;
      end
      assign res = k_i[i] ? shift_by(src, 1 << i, op_i) : src;
   end

   assign work_o = g_lvl[K_W-1].res;

endmodule

// File: rtl/shift_unit_iter.sv
// -----------------------------------------------------------------------------
// shift_unit_iter
//   Multi-cycle shift unit (SLL / SRL / SRA / ROL, any amount 0..WIDTH-1).
//   Moves at most STEP positions per cycle through shift_step_unit, so the
//   per-cycle network is narrow. Latency from accept to first out_valid is
//   1 + ceil(shamt/STEP); the result is held under unlimited backpressure.
//   Ports:
//     clock  in  1      posedge clock
//     reset  in  1      synchronous, active-high; aborts any operation
//     bus    slave      in_valid/in_ready/data_in/shamt/op request,
//                       out_valid/out_ready/data_out response
// -----------------------------------------------------------------------------
module shift_unit_iter
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int STEP    = 4
) (
   input  logic               clock,
   input  logic               reset,
   shift_unit_iter_if.slave   bus
);

   localparam int K_W = $clog2(STEP+1);

   shift_state_t       state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   shift_op_t          op_q, op_d;

   logic               accept;
   logic [SHAMT_W-1:0] shamt_c;
   logic [K_W-1:0]     k;
   logic [SHAMT_W-1:0] rem_after;
   logic [WIDTH-1:0]   stepped;
   int                 rem_int;
   int                 k_int;

   // Only reachable when WIDTH is not a power of two.
   assign shamt_c = (int'(bus.shamt) >= WIDTH) ? SHAMT_W'(WIDTH - 1) : bus.shamt;
   assign accept  = bus.in_valid && bus.in_ready;

   always_comb begin
      rem_int   = int'(rem_q);
      k_int     = (rem_int > STEP) ? STEP : rem_int;
      k         = K_W'(k_int);
      rem_after = SHAMT_W'(rem_int - k_int);
   end

   shift_step_unit #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .work_i (work_q),
      .k_i    (k),
      .op_i   (op_q),
      .work_o (stepped)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = (shamt_c == '0) ? ST_DONE : ST_SHIFT;
         ST_SHIFT: if (rem_after == '0) state_d = ST_DONE;
         ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.in_ready  = (state_q == ST_IDLE) && !reset;
      bus.out_valid = (state_q == ST_DONE);
   end

   assign bus.data_out = work_q;

   // Datapath next state: load on accept, step while shifting, hold otherwise
   always_comb begin
      work_d = work_q;
      rem_d  = rem_q;
      op_d   = op_q;
      if (state_q == ST_IDLE && accept) begin
         work_d = bus.data_in;
         rem_d  = shamt_c;
         op_d   = bus.op;
      end else if (state_q == ST_SHIFT) begin
         work_d = stepped;
         rem_d  = rem_after;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         work_q <= '0;
         rem_q  <= '0;
         op_q   <= SHIFT_OP_SLL;
      end else begin
         work_q <= work_d;
         rem_q  <= rem_d;
         op_q   <= op_d;
      end
   end

endmodule

// File: tb/tb_shift_unit_iter.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_iter
//   Directed bench for shift_unit_iter at WIDTH=32 with three instances:
//   STEP=1 (index 0), STEP=4 (index 1), STEP=32 (index 2).
// -----------------------------------------------------------------------------
module tb_shift_unit_iter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int steps_of [3] = '{1, 4, 32};

   logic        tb_in_valid  [3];
   logic [31:0] tb_data_in   [3];
   logic [4:0]  tb_shamt     [3];
   logic [1:0]  tb_op        [3];
   logic        tb_out_ready [3];
   logic        w_in_ready   [3];
   logic        w_out_valid  [3];
   logic [31:0] w_data_out   [3];

   shift_unit_iter_if #(.WIDTH(32), .SHAMT_W(5)) if_s1 ();
   shift_unit_iter_if #(.WIDTH(32), .SHAMT_W(5)) if_s4 ();
   shift_unit_iter_if #(.WIDTH(32), .SHAMT_W(5)) if_s32 ();

   assign if_s1.in_valid  = tb_in_valid[0];
   assign if_s1.data_in   = tb_data_in[0];
   assign if_s1.shamt     = tb_shamt[0];
   assign if_s1.op        = tb_op[0];
   assign if_s1.out_ready = tb_out_ready[0];
   assign w_in_ready[0]   = if_s1.in_ready;
   assign w_out_valid[0]  = if_s1.out_valid;
   assign w_data_out[0]   = if_s1.data_out;

   assign if_s4.in_valid  = tb_in_valid[1];
   assign if_s4.data_in   = tb_data_in[1];
   assign if_s4.shamt     = tb_shamt[1];
   assign if_s4.op        = tb_op[1];
   assign if_s4.out_ready = tb_out_ready[1];
   assign w_in_ready[1]   = if_s4.in_ready;
   assign w_out_valid[1]  = if_s4.out_valid;
   assign w_data_out[1]   = if_s4.data_out;

   assign if_s32.in_valid  = tb_in_valid[2];
   assign if_s32.data_in   = tb_data_in[2];
   assign if_s32.shamt     = tb_shamt[2];
   assign if_s32.op        = tb_op[2];
   assign if_s32.out_ready = tb_out_ready[2];
   assign w_in_ready[2]    = if_s32.in_ready;
   assign w_out_valid[2]   = if_s32.out_valid;
   assign w_data_out[2]    = if_s32.data_out;

   shift_unit_iter #(.WIDTH(32), .SHAMT_W(5), .STEP(1))  dut_s1  (.clock(clk), .reset(rst), .bus(if_s1));
   shift_unit_iter #(.WIDTH(32), .SHAMT_W(5), .STEP(4))  dut_s4  (.clock(clk), .reset(rst), .bus(if_s4));
   shift_unit_iter #(.WIDTH(32), .SHAMT_W(5), .STEP(32)) dut_s32 (.clock(clk), .reset(rst), .bus(if_s32));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: a single shift by the full amount.
   function automatic logic [31:0] model(input logic [31:0] d, input int sh, input logic [1:0] op);
      logic signed [31:0] sd;
      sd = d;
      case (op)
         2'b00:   model = d << sh;
         2'b01:   model = d >> sh;
         2'b10:   model = $unsigned(sd >>> sh);
         default: model = (sh == 0) ? d : ((d << sh) | (d >> (32 - sh)));
      endcase
   endfunction

   // One complete transaction on instance d; inputs change #1 after posedge.
   task automatic do_op(input int d, input logic [31:0] data, input logic [4:0] sh,
                        input logic [1:0] op, input logic [31:0] exp, input int exp_lat,
                        input string tag);
      int lat;
      check({tag, "_in_ready"}, 32'(w_in_ready[d]), 32'd1);
      tb_in_valid[d] = 1'b1;
      tb_data_in[d]  = data;
      tb_shamt[d]    = sh;
      tb_op[d]       = op;
      @(posedge clk); #1;
      tb_in_valid[d] = 1'b0;
      lat = 1;
      while (!w_out_valid[d] && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_data"}, w_data_out[d], exp);
      tb_out_ready[d] = 1'b1;
      @(posedge clk); #1;
      tb_out_ready[d] = 1'b0;
      check({tag, "_released"}, 32'(w_out_valid[d]), 32'd0);
   endtask

   initial begin
      logic [31:0] rnd;
      int          lat_exp;
      for (int i = 0; i < 3; i++) begin
         tb_in_valid[i]  = 1'b0;
         tb_data_in[i]   = '0;
         tb_shamt[i]     = '0;
         tb_op[i]        = '0;
         tb_out_ready[i] = 1'b0;
      end

      // Reset state
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_out_valid_%0d", i), 32'(w_out_valid[i]), 32'd0);
         check($sformatf("rst_data_out_%0d", i), w_data_out[i], 32'd0);
         check($sformatf("rst_in_ready_%0d", i), 32'(w_in_ready[i]), 32'd0);
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++)
         check($sformatf("post_rst_in_ready_%0d", i), 32'(w_in_ready[i]), 32'd1);

      // Directed vectors, STEP=4
      do_op(1, 32'd7,          5'd2,  2'b00, 32'd28,         2, "sll_7_by_2");
      do_op(1, 32'd7987,       5'd31, 2'b00, 32'h8000_0000,  9, "sll_7987_by_31");
      do_op(1, 32'h8000_0000,  5'd31, 2'b10, 32'hFFFF_FFFF,  9, "sra_min_by_31");
      do_op(1, 32'h8000_0000,  5'd31, 2'b01, 32'h0000_0001,  9, "srl_min_by_31");
      do_op(1, 32'h8000_0001,  5'd4,  2'b11, 32'h0000_0018,  2, "rol_by_4");
      do_op(1, 32'd52355257,   5'd0,  2'b00, 32'd52355257,   1, "sll_by_0");
      do_op(1, 32'd52355257,   5'd0,  2'b01, 32'd52355257,   1, "srl_by_0");
      do_op(1, 32'd52355257,   5'd0,  2'b10, 32'd52355257,   1, "sra_by_0");
      do_op(1, 32'd52355257,   5'd0,  2'b11, 32'd52355257,   1, "rol_by_0");

      // Backpressure: result held, no second accept while in_valid stays high
      tb_in_valid[1] = 1'b1;
      tb_data_in[1]  = 32'd7;
      tb_shamt[1]    = 5'd2;
      tb_op[1]       = 2'b00;
      @(posedge clk); #1;
      tb_data_in[1]  = 32'h0000_1234;
      tb_shamt[1]    = 5'd0;
      @(posedge clk); #1;
      check("bp_first_valid", 32'(w_out_valid[1]), 32'd1);
      check("bp_first_data", w_data_out[1], 32'd28);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp_hold_data_%0d", c), w_data_out[1], 32'd28);
         check($sformatf("bp_hold_valid_%0d", c), 32'(w_out_valid[1]), 32'd1);
         check($sformatf("bp_hold_in_ready_%0d", c), 32'(w_in_ready[1]), 32'd0);
      end
      tb_out_ready[1] = 1'b1;
      @(posedge clk); #1;
      tb_out_ready[1] = 1'b0;
      check("bp_idle_valid", 32'(w_out_valid[1]), 32'd0);
      check("bp_idle_in_ready", 32'(w_in_ready[1]), 32'd1);
      @(posedge clk); #1;
      tb_in_valid[1] = 1'b0;
      check("bp_second_valid", 32'(w_out_valid[1]), 32'd1);
      check("bp_second_data", w_data_out[1], 32'h0000_1234);
      tb_out_ready[1] = 1'b1;
      @(posedge clk); #1;
      tb_out_ready[1] = 1'b0;

      // Reset three cycles into a long shift
      tb_in_valid[1] = 1'b1;
      tb_data_in[1]  = 32'd7987;
      tb_shamt[1]    = 5'd31;
      tb_op[1]       = 2'b00;
      @(posedge clk); #1;
      tb_in_valid[1] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_out_valid", 32'(w_out_valid[1]), 32'd0);
      check("abort_data_out", w_data_out[1], 32'd0);
      check("abort_in_ready_in_reset", 32'(w_in_ready[1]), 32'd0);
      rst = 1'b0;
      #1;
      check("abort_in_ready_after", 32'(w_in_ready[1]), 32'd1);
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         check($sformatf("abort_no_result_%0d", c), 32'(w_out_valid[1]), 32'd0);
      end

      // Sweep: every op and amount with random data on all three step sizes
      for (int d = 0; d < 3; d++) begin
         for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 32; s++) begin
               rnd     = $urandom;
               lat_exp = 1 + (s + steps_of[d] - 1) / steps_of[d];
               do_op(d, rnd, 5'(s), 2'(o), model(rnd, s, 2'(o)), lat_exp,
                     $sformatf("sweep_step%0d_op%0d_sh%0d", steps_of[d], o, s));
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
